// File: rtl/design1_wrapper_if.sv
// AXI4-Lite slave bus bundle for the DMA register-window model.
// The master modport is driven by the bus owner; the slave modport is used by design1_wrapper.
interface design1_wrapper_if;
  logic [31:0] s_axi_awaddr;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [31:0] s_axi_araddr;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready;

  modport master (
    output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
           s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
    input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
           s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );

  modport slave (
    input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
           s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
    output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
           s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );
endinterface

// File: rtl/design1_wrapper.sv
// Register-level stand-in for four AXI DMA channels (MM2S + S2MM each): AXI4-Lite
// register window, timed fake transfers and per-channel IOC interrupts.
module design1_wrapper #(
  parameter logic [31:0] BASE_ADDR       = 32'h4000_0000,
  parameter int          INTERRUPT_DELAY = 40
) (
  input  logic              ps_clk,
  input  logic              ps_reset,
  design1_wrapper_if.slave  s_axi,
  output logic [3:0]        irq
);

  logic        r_awready, r_bvalid, r_arready, r_rvalid;
  logic [1:0]  r_bresp, r_rresp;
  logic [31:0] r_rdata;
  logic [3:0]  r_irq;

  // Engine index is {channel, s2mm}, so channel c owns engines 2c and 2c+1.
  logic        r_rs       [8];
  logic        r_ioc_en   [8];
  logic        r_ioc      [8];
  logic        r_busy     [8];
  logic        r_rst_pend [8];
  logic [15:0] r_cnt      [8];
  logic [31:0] r_curr     [8];
  logic [31:0] r_tail     [8];

  logic        w_wr_fire, w_wr_map, w_wr_ok, w_rd_fire, w_rd_map, w_rd_ok;
  logic [2:0]  w_wr_eng, w_wr_reg, w_rd_eng, w_rd_reg;
  logic [31:0] w_mask, w_wr_val, w_rd_word;
  logic        w_unused;

  function automatic logic f_mapped(input logic [31:0] a);
    return a[31:16] == BASE_ADDR[31:16];
  endfunction

  function automatic logic f_reg_ok(input logic [31:0] a);
    return (a[7:6] == 2'b00) && (a[4:2] <= 3'd5);
  endfunction

  assign w_wr_fire = r_awready & s_axi.s_axi_awvalid & s_axi.s_axi_wvalid;
  assign w_wr_map  = f_mapped(s_axi.s_axi_awaddr);
  assign w_wr_ok   = w_wr_map & f_reg_ok(s_axi.s_axi_awaddr);
  assign w_wr_eng  = {s_axi.s_axi_awaddr[15:14], s_axi.s_axi_awaddr[5]};
  assign w_wr_reg  = s_axi.s_axi_awaddr[4:2];
  assign w_mask    = {{8{s_axi.s_axi_wstrb[3]}}, {8{s_axi.s_axi_wstrb[2]}},
                      {8{s_axi.s_axi_wstrb[1]}}, {8{s_axi.s_axi_wstrb[0]}}};
  assign w_wr_val  = s_axi.s_axi_wdata & w_mask;

  assign w_rd_fire = r_arready & s_axi.s_axi_arvalid;
  assign w_rd_map  = f_mapped(s_axi.s_axi_araddr);
  assign w_rd_ok   = w_rd_map & f_reg_ok(s_axi.s_axi_araddr);
  assign w_rd_eng  = {s_axi.s_axi_araddr[15:14], s_axi.s_axi_araddr[5]};
  assign w_rd_reg  = s_axi.s_axi_araddr[4:2];

  assign w_unused  = ^{s_axi.s_axi_awaddr[13:8], s_axi.s_axi_awaddr[1:0],
                       s_axi.s_axi_araddr[13:8], s_axi.s_axi_araddr[1:0]};

  always_comb begin
    w_rd_word = '0;
    if (w_rd_ok) begin
      case (w_rd_reg)
        3'd0: begin
          w_rd_word[0]  = r_rs[w_rd_eng];
          w_rd_word[12] = r_ioc_en[w_rd_eng];
        end
        3'd1: begin
          w_rd_word[0]  = !r_rs[w_rd_eng];
          w_rd_word[1]  = r_rs[w_rd_eng] & !r_busy[w_rd_eng];
          w_rd_word[12] = r_ioc[w_rd_eng];
        end
        3'd2:    w_rd_word = r_curr[w_rd_eng];
        3'd4:    w_rd_word = r_tail[w_rd_eng];
        default: w_rd_word = '0;
      endcase
    end
  end

  // AXI handshake: ready pulses one cycle once both channels are valid, response follows.
  always_ff @(posedge ps_clk) begin
    r_awready <= s_axi.s_axi_awvalid & s_axi.s_axi_wvalid & !r_awready & !r_bvalid;
    r_arready <= s_axi.s_axi_arvalid & !r_arready & !r_rvalid;
    if (w_wr_fire) begin
      r_bvalid <= 1'b1;
      r_bresp  <= w_wr_map ? 2'b00 : 2'b11;
    end else if (r_bvalid && s_axi.s_axi_bready) begin
      r_bvalid <= 1'b0;
    end
    if (w_rd_fire) begin
      r_rvalid <= 1'b1;
      r_rresp  <= w_rd_map ? 2'b00 : 2'b11;
      r_rdata  <= w_rd_word;
    end else if (r_rvalid && s_axi.s_axi_rready) begin
      r_rvalid <= 1'b0;
    end
    for (int c = 0; c < 4; c++) begin
      r_irq[c] <= (r_ioc[2*c] & r_ioc_en[2*c]) | (r_ioc[2*c+1] & r_ioc_en[2*c+1]);
    end
    if (ps_reset) begin
      r_awready <= 1'b0;
      r_arready <= 1'b0;
      r_bvalid  <= 1'b0;
      r_rvalid  <= 1'b0;
      r_bresp   <= 2'b00;
      r_rresp   <= 2'b00;
      r_rdata   <= '0;
      r_irq     <= '0;
    end
  end

  // Engine state: completion first, then register writes override where they must.
  always_ff @(posedge ps_clk) begin
    for (int e = 0; e < 8; e++) begin
      r_rst_pend[e] <= 1'b0;
      if (r_busy[e]) begin
        if (r_cnt[e] == 16'd1) begin
          r_busy[e] <= 1'b0;
          r_ioc[e]  <= 1'b1;
          r_curr[e] <= r_tail[e];
        end else begin
          r_cnt[e] <= r_cnt[e] - 16'd1;
        end
      end
      if (w_wr_fire && w_wr_ok && (w_wr_eng == 3'(e))) begin
        case (w_wr_reg)
          3'd0: begin
            if (s_axi.s_axi_wstrb[0]) begin
              r_rs[e]       <= s_axi.s_axi_wdata[0];
              r_rst_pend[e] <= s_axi.s_axi_wdata[2];
              if (!s_axi.s_axi_wdata[0] && r_busy[e]) begin
                // Abort: undo any completion scheduled in this same cycle.
                r_busy[e] <= 1'b0;
                r_ioc[e]  <= r_ioc[e];
                r_curr[e] <= r_curr[e];
              end
            end
            if (s_axi.s_axi_wstrb[1]) r_ioc_en[e] <= s_axi.s_axi_wdata[12];
          end
          3'd1: begin
            if (s_axi.s_axi_wstrb[1] && s_axi.s_axi_wdata[12] &&
                !(r_busy[e] && r_cnt[e] == 16'd1))
              r_ioc[e] <= 1'b0;
          end
          3'd2: begin
            if (!r_rs[e]) r_curr[e] <= ((r_curr[e] & ~w_mask) | w_wr_val) & ~32'h3F;
          end
          3'd4: begin
            r_tail[e] <= ((r_tail[e] & ~w_mask) | w_wr_val) & ~32'h3F;
            if (r_rs[e] && !r_busy[e]) begin
              r_busy[e] <= 1'b1;
              r_cnt[e]  <= 16'(INTERRUPT_DELAY);
            end
          end
          default: ;
        endcase
      end
      if (ps_reset || r_rst_pend[e]) begin
        r_rs[e]       <= 1'b0;
        r_ioc_en[e]   <= 1'b0;
        r_ioc[e]      <= 1'b0;
        r_busy[e]     <= 1'b0;
        r_cnt[e]      <= '0;
        r_curr[e]     <= '0;
        r_tail[e]     <= '0;
        r_rst_pend[e] <= 1'b0;
      end
    end
  end

  assign s_axi.s_axi_awready = r_awready;
  assign s_axi.s_axi_wready  = r_awready;
  assign s_axi.s_axi_bvalid  = r_bvalid;
  assign s_axi.s_axi_bresp   = r_bresp;
  assign s_axi.s_axi_arready = r_arready;
  assign s_axi.s_axi_rvalid  = r_rvalid;
  assign s_axi.s_axi_rresp   = r_rresp;
  assign s_axi.s_axi_rdata   = r_rdata;
  assign irq                 = r_irq;

endmodule

// File: tb/tb_design1_wrapper.sv
// Directed bench for design1_wrapper: register access, transfer timing, abort, reset and handshakes.
module tb_design1_wrapper;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] irq;
  int         n_chk = 0;
  int         n_err = 0;
  logic [31:0] rd, rd2;
  logic [1:0]  rsp, rsp2;

  design1_wrapper_if bus();

  design1_wrapper #(.BASE_ADDR(32'h4000_0000), .INTERRUPT_DELAY(40)) dut (
    .ps_clk   (clk),
    .ps_reset (rst),
    .s_axi    (bus.slave),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    int n;
    @(posedge clk); #1;
    bus.s_axi_awaddr = a; bus.s_axi_awvalid = 1'b1;
    bus.s_axi_wdata = d; bus.s_axi_wstrb = s; bus.s_axi_wvalid = 1'b1;
    bus.s_axi_bready = 1'b1;
    n = 0;
    while (!bus.s_axi_awready && n < 20) begin cyc(1); n++; end
    if (!bus.s_axi_awready) chk("wr_awready_timeout", {31'b0, bus.s_axi_awready}, 1);
    cyc(1);
    bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0;
    n = 0;
    while (!bus.s_axi_bvalid && n < 20) begin cyc(1); n++; end
    if (!bus.s_axi_bvalid) chk("wr_bvalid_timeout", {31'b0, bus.s_axi_bvalid}, 1);
    resp = bus.s_axi_bresp;
    cyc(1);
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    @(posedge clk); #1;
    bus.s_axi_araddr = a; bus.s_axi_arvalid = 1'b1; bus.s_axi_rready = 1'b1;
    n = 0;
    while (!bus.s_axi_arready && n < 20) begin cyc(1); n++; end
    if (!bus.s_axi_arready) chk("rd_arready_timeout", {31'b0, bus.s_axi_arready}, 1);
    cyc(1);
    bus.s_axi_arvalid = 1'b0;
    n = 0;
    while (!bus.s_axi_rvalid && n < 20) begin cyc(1); n++; end
    if (!bus.s_axi_rvalid) chk("rd_rvalid_timeout", {31'b0, bus.s_axi_rvalid}, 1);
    d = bus.s_axi_rdata; resp = bus.s_axi_rresp;
    cyc(1);
  endtask

  initial begin
    bus.s_axi_awaddr = '0; bus.s_axi_awvalid = 1'b0; bus.s_axi_wdata = '0;
    bus.s_axi_wstrb = '0; bus.s_axi_wvalid = 1'b0; bus.s_axi_bready = 1'b0;
    bus.s_axi_araddr = '0; bus.s_axi_arvalid = 1'b0; bus.s_axi_rready = 1'b0;
    cyc(3);
    chk("rst_outputs", {irq, bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_bvalid,
                        bus.s_axi_arready, bus.s_axi_rvalid}, 32'h0);
    chk("rst_rdata", bus.s_axi_rdata, 32'h0);
    rst = 1'b0;
    cyc(1);

    axi_read(32'h4000_0004, rd, rsp);
    chk("rst_dmasr", rd, 32'h0000_0001);
    chk("rst_dmasr_resp", {30'b0, rsp}, 0);

    // Transfer on FFT_TX MM2S with interrupt enabled.
    axi_write(32'h4000_4008, 32'h1000, 4'hF, rsp);
    axi_write(32'h4000_4000, 32'h1001, 4'hF, rsp);
    axi_read(32'h4000_4000, rd, rsp);
    chk("dmacr_rb", rd, 32'h1001);
    axi_write(32'h4000_4010, 32'h1040, 4'hF, rsp);
    cyc(38);
    chk("irq_early", {28'b0, irq}, 0);
    cyc(1);
    chk("irq_reg_lag", {28'b0, irq}, 0);
    cyc(1);
    chk("irq_fft_tx", {28'b0, irq}, 32'h2);
    axi_read(32'h4000_4004, rd, rsp);
    chk("dmasr_done", rd, 32'h1002);
    axi_read(32'h4000_4008, rd, rsp);
    chk("curr_done", rd, 32'h1040);
    axi_write(32'h4000_4008, 32'h5000, 4'hF, rsp);
    chk("curr_ro_resp", {30'b0, rsp}, 0);
    axi_read(32'h4000_4008, rd, rsp);
    chk("curr_ro_rs1", rd, 32'h1040);
    axi_write(32'h4000_4004, 32'h1000, 4'hF, rsp);
    chk("irq_cleared", {28'b0, irq}, 0);
    axi_read(32'h4000_4004, rd, rsp);
    chk("dmasr_cleared", rd, 32'h0002);

    // Abort on VGA S2MM.
    axi_write(32'h4000_C020, 32'h1001, 4'hF, rsp);
    axi_write(32'h4000_C030, 32'h2000, 4'hF, rsp);
    cyc(8);
    axi_write(32'h4000_C020, 32'h1000, 4'hF, rsp);
    axi_read(32'h4000_C024, rd, rsp);
    chk("abort_dmasr", rd, 32'h0001);
    cyc(50);
    chk("abort_irq", {28'b0, irq}, 0);
    axi_read(32'h4000_C028, rd, rsp);
    chk("abort_curr", rd, 32'h0);

    // Decode errors and unused offsets.
    axi_read(32'h5000_0000, rd, rsp);
    chk("unmap_rresp", {30'b0, rsp}, 32'h3);
    chk("unmap_rdata", rd, 32'h0);
    axi_write(32'h5000_0008, 32'hABC0, 4'hF, rsp);
    chk("unmap_bresp", {30'b0, rsp}, 32'h3);
    axi_read(32'h4000_0008, rd, rsp);
    chk("unmap_nochange", rd, 32'h0);
    axi_write(32'h4000_003C, 32'hFFFF_FFFF, 4'hF, rsp);
    chk("unused_bresp", {30'b0, rsp}, 0);
    axi_read(32'h4000_0020, rd, rsp);
    chk("unused_nochange", rd, 32'h0);
    axi_read(32'h4000_000C, rd, rsp);
    chk("msb_zero", rd, 32'h0);

    // Byte strobes and low-bit masking.
    axi_write(32'h4000_0008, 32'hAABB_CCDD, 4'b0011, rsp);
    axi_read(32'h4000_0008, rd, rsp);
    chk("strb_low", rd, 32'h0000_CCC0);
    axi_write(32'h4000_0008, 32'h1122_3344, 4'b1100, rsp);
    axi_read(32'h4000_0008, rd, rsp);
    chk("strb_high", rd, 32'h1122_CCC0);

    // DMACR.Reset affects only its own engine.
    axi_write(32'h4000_0028, 32'h3000, 4'hF, rsp);
    axi_write(32'h4000_0000, 32'h1005, 4'hF, rsp);
    axi_read(32'h4000_0000, rd, rsp);
    chk("selfrst_dmacr", rd, 32'h0);
    axi_read(32'h4000_0008, rd, rsp);
    chk("selfrst_curr", rd, 32'h0);
    axi_read(32'h4000_0028, rd, rsp);
    chk("selfrst_other", rd, 32'h3000);

    // Concurrent read and write.
    fork
      axi_write(32'h4000_C010, 32'h7000, 4'hF, rsp2);
      axi_read(32'h4000_4008, rd2, rsp);
    join
    chk("conc_rd", rd2, 32'h1040);
    axi_read(32'h4000_C010, rd, rsp);
    chk("conc_wr", rd, 32'h7000);

    // AW then W one cycle later, bready held low.
    @(posedge clk); #1;
    bus.s_axi_awaddr = 32'h4000_8010; bus.s_axi_awvalid = 1'b1; bus.s_axi_bready = 1'b0;
    cyc(1);
    chk("split_no_ready", {30'b0, bus.s_axi_awready, bus.s_axi_bvalid}, 0);
    bus.s_axi_wdata = 32'h2025; bus.s_axi_wstrb = 4'hF; bus.s_axi_wvalid = 1'b1;
    for (int n = 0; n < 20 && !bus.s_axi_awready; n++) cyc(1);
    chk("split_ready", {30'b0, bus.s_axi_awready, bus.s_axi_wready}, 32'h3);
    cyc(1);
    bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0;
    chk("split_bvalid", {31'b0, bus.s_axi_bvalid}, 1);
    cyc(5);
    chk("bvalid_held", {30'b0, bus.s_axi_bvalid, bus.s_axi_awready}, 32'h2);
    bus.s_axi_bready = 1'b1;
    cyc(1);
    chk("bvalid_drop", {31'b0, bus.s_axi_bvalid}, 0);
    axi_read(32'h4000_8010, rd, rsp);
    chk("split_data", rd, 32'h2000);

    // Global reset mid-transfer on FFT_RX.
    axi_write(32'h4000_8000, 32'h1001, 4'hF, rsp);
    axi_write(32'h4000_8010, 32'h2040, 4'hF, rsp);
    cyc(5);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    axi_read(32'h4000_8004, rd, rsp);
    chk("rst_mid_dmasr", rd, 32'h0001);
    cyc(50);
    chk("rst_mid_irq", {28'b0, irq}, 0);
    axi_read(32'h4000_8010, rd, rsp);
    chk("rst_mid_tail", rd, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
